// File: rtl/riscv_core_pkg.sv
// Shared constants and helpers for the core's arbitration and muxing blocks.
package riscv_core_pkg;

  localparam int XLEN_DEF = 64;

  localparam bit ARB_MODE_FIXED = 1'b0;
  localparam bit ARB_MODE_RR    = 1'b1;

  // Channel-index width; a single channel still needs one bit to carry an index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_core_rr_arbiter.sv
// Combinational N-way arbiter: fixed priority (lowest index) or round-robin
// starting at ptr and wrapping upward.
module riscv_core_rr_arbiter
  import riscv_core_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  bit RR_EN  = ARB_MODE_RR,
  localparam int IDX_W  = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  always_comb begin
    int base;
    int k;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    base    = RR_EN ? int'(ptr) : 0;
    k       = 0;
    // Walk the channels starting at base; the first request seen wins.
    for (int i = 0; i < NUM_IN; i++) begin
      k = (base + i) % NUM_IN;
      if (!any_gnt && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_core_arb_muxn.sv
// N-input arbitrating mux with a one-entry registered output stage and
// valid/ready handshakes on every channel.
module riscv_core_arb_muxn
  import riscv_core_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NUM_IN = 4,
  parameter  bit RR_EN  = ARB_MODE_RR,
  localparam int IDX_W  = idx_w(NUM_IN)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_arb_flush,
  input  logic [NUM_IN-1:0]      i_arb_in_valid,
  input  logic [NUM_IN*XLEN-1:0] i_arb_in_data,
  output logic [NUM_IN-1:0]      o_arb_in_ready,
  output logic                   o_arb_out_valid,
  output logic [XLEN-1:0]        o_arb_out_data,
  output logic [IDX_W-1:0]       o_arb_out_idx,
  input  logic                   i_arb_out_ready
);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_num_in_chk
    $error("riscv_core_arb_muxn: NUM_IN must be in 2..16");
  end

  logic [NUM_IN-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [XLEN-1:0]   sel_data;
  logic              slot_free;
  logic              in_fire;
  logic              out_fire;

  riscv_core_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .RR_EN  (RR_EN)
  ) u_arb (
    .req     (i_arb_in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // One-hot AND-OR select keeps the payload path shallow.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      sel_data |= {XLEN{gnt[k]}} & i_arb_in_data[k*XLEN +: XLEN];
  end

  // Consumer accepting this cycle frees the slot for a same-edge refill.
  assign slot_free      = !o_arb_out_valid || i_arb_out_ready;
  assign o_arb_in_ready = (slot_free && !i_arb_flush && i_rst_n) ? gnt : '0;
  assign in_fire        = |o_arb_in_ready;
  assign out_fire       = o_arb_out_valid && i_arb_out_ready;

  always_comb begin
    ptr_nxt = '0;
    if (RR_EN && gnt_idx != IDX_W'(NUM_IN - 1))
      ptr_nxt = gnt_idx + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_arb_out_valid <= 1'b0;
      o_arb_out_data  <= '0;
      o_arb_out_idx   <= '0;
      ptr             <= '0;
    end else if (i_arb_flush) begin
      o_arb_out_valid <= 1'b0;
      ptr             <= '0;
    end else if (in_fire) begin
      o_arb_out_valid <= 1'b1;
      o_arb_out_data  <= sel_data;
      o_arb_out_idx   <= gnt_idx;
      ptr             <= ptr_nxt;
    end else if (out_fire) begin
      o_arb_out_valid <= 1'b0;
    end
  end

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_arb_in_ready));

  a_stall_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n || i_arb_flush)
    (o_arb_out_valid && !i_arb_out_ready) |=>
      (o_arb_out_valid && $stable(o_arb_out_data) && $stable(o_arb_out_idx)));

endmodule

// File: doc/riscv_core_arb_muxn.md
Name: riscv_core_arb_muxn

Overview:
- Parametrised N-input, XLEN-wide arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Generalises the core's static select muxes.
  - Grant is computed each cycle, by fixed priority or round-robin.
  - The winning payload is captured into a one-entry output register and held until the consumer accepts it.
- Used where several core sources share one downstream path, e.g. writeback/LSU request merging.

Parameters:
- XLEN, 64, data width of each channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- IDX_W, localparam = $clog2(NUM_IN), width of the channel index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_arb_flush  input  1  synchronous flush: drops the held output, resets the RR pointer.
- i_arb_in_valid  input  NUM_IN  per-channel request valid.
- i_arb_in_data  input  NUM_IN*XLEN  flattened payloads; channel k occupies bits [k*XLEN +: XLEN].
- o_arb_in_ready  output  NUM_IN  one-hot (or zero) acceptance per channel.
- o_arb_out_valid  output  1  output register holds a payload.
- o_arb_out_data  output  XLEN  held payload.
- o_arb_out_idx  output  IDX_W  source channel of the held payload.
- i_arb_out_ready  input  1  consumer accepts the held payload.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_arb_out_valid=0, o_arb_out_data=0, o_arb_out_idx=0.
  - RR pointer = 0.
  - o_arb_in_ready is combinationally 0 while in reset.
- Output slot:
  - Output slot is free when o_arb_out_valid=0, or when i_arb_out_ready=1 (pass-through refill, full throughput).
- Grant:
  - Combinational.
  - Fixed mode: lowest index k with i_arb_in_valid[k]=1.
  - RR mode: first valid channel at or after the pointer, searching upward with wrap from NUM_IN-1 to 0.
- Ready:
  - o_arb_in_ready[k] = slot free AND grant==k AND no flush.
  - At most one ready bit is set.
  - Ready must not depend on i_arb_in_valid of the same channel except through the grant.
- Capture:
  - On input fire, o_arb_out_data ← chosen payload, o_arb_out_idx ← k, o_arb_out_valid ← 1.
  - Latency is exactly 1 cycle from fire to valid output.
- Drain: output fire with no input fire → o_arb_out_valid ← 0; data and idx hold their last values.
- Stall: o_arb_out_valid=1 and i_arb_out_ready=0 → data, idx and valid are stable; no input is accepted.
- RR pointer update:
  - On input fire, pointer ← (k+1) mod NUM_IN.
  - Pointer is unchanged when there is no fire.
  - Pointer is unused and held at 0 when RR_EN=0.
- Flush:
  - o_arb_out_valid ← 0 and pointer ← 0 next edge.
  - No input fires in the flush cycle.
  - Flush wins over simultaneous output fire and input fire.
- No requests: grant is don't-care, all ready bits are 0, state holds apart from drain.
- Simultaneous drain and refill: the new payload replaces the old in the same edge; valid stays 1.
- Reset mid-transaction: the held payload is lost and the pointer returns to 0; the consumer must not see a stale valid after reset release.
- Assertions:
  - $onehot0(o_arb_in_ready).
  - Output stable while valid && !ready.
  - NUM_IN within range (elaboration check).

Decomposition:
- Shared package riscv_core_pkg:
  - XLEN default constant.
  - ARB_MODE_FIXED/ARB_MODE_RR constants.
  - Helper function for the channel-index width.
- Sub-module riscv_core_rr_arbiter:
  - Parametrised by NUM_IN and RR_EN.
  - Inputs: request vector, pointer. Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational, so it can be reused by future multi-port blocks.
- Top level owns the output register, pointer, flush and handshake logic.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 3 cycles, release with no valids → out_valid=0, out_data=0, all in_ready=0 indefinitely.
- Fixed priority (RR_EN=0): valid=4'b1010, data1=0x11, data3=0x33, out_ready=1 → cycle+1: idx=1, data=0x11. Keeping ch1 valid starves ch3 every cycle.
- Round-robin (RR_EN=1): all 4 channels continuously valid with data=k, out_ready=1 → output idx sequence 0,1,2,3,0,… with one payload per cycle.
- Backpressure: capture ch2 payload 0xDEAD, hold out_ready=0 for 5 cycles while ch0/ch1 valid → data stays 0xDEAD, in_ready=0. Raise out_ready → 0xDEAD drains and ch3's successor (RR from pointer 3, wrapping to 0) is captured the same edge.
- Flush collision: out_valid=1, out_ready=1, ch1 valid, flush=1 → next cycle out_valid=0, ch1 not accepted, pointer=0. Next grant with all valid is idx 0.
- Async reset mid-stall: out_valid=1 with data 0xBEEF, assert i_rst_n low between clock edges → out_valid drops immediately, no edge required. After release, the first grant with all channels valid is idx 0.
